// File: rtl/spatz_cache_port_merger.sv
// Merges two Spatz core request ports onto one cache bank port (round-robin with line lock),
// tags requests with the core ID, limits outstanding requests and steers responses back.
// Optional statistics counters: `define SPATZ_PORT_MERGER_STATS_EN.
module spatz_cache_port_merger #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned UserWidth      = 8,
    parameter int unsigned CoreIdBit      = 0,
    parameter int unsigned LineOffset     = 6,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned LockMax        = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [2*AddrWidth-1:0]     inp_addr_i,
    input  logic [1:0]                 inp_write_i,
    input  logic [2*DataWidth-1:0]     inp_data_i,
    input  logic [2*DataWidth/8-1:0]   inp_strb_i,
    input  logic [2*UserWidth-1:0]     inp_user_i,
    input  logic [1:0]                 inp_valid_i,
    output logic [1:0]                 inp_ready_o,
    output logic [AddrWidth-1:0]       oup_addr_o,
    output logic                       oup_write_o,
    output logic [DataWidth-1:0]       oup_data_o,
    output logic [DataWidth/8-1:0]     oup_strb_o,
    output logic [UserWidth-1:0]       oup_user_o,
    output logic                       oup_valid_o,
    input  logic                       oup_ready_i,
    input  logic [DataWidth-1:0]       rsp_data_i,
    input  logic [UserWidth-1:0]       rsp_user_i,
    input  logic                       rsp_valid_i,
    output logic                       rsp_ready_o,
    output logic [2*DataWidth-1:0]     core_rsp_data_o,
    output logic [1:0]                 core_rsp_valid_o,
    input  logic [1:0]                 core_rsp_ready_i,
    input  logic                       flush_i,
    output logic                       drained_o
`ifdef SPATZ_PORT_MERGER_STATS_EN
    ,
    output logic [63:0]                stat_grant_o,
    output logic [31:0]                stat_lock_o,
    output logic [31:0]                stat_stall_o
`endif
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned LineWidth = AddrWidth - LineOffset;
    localparam int unsigned CntWidth  = 8;
    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);
    localparam logic [CntWidth-1:0] LockLim = CntWidth'(LockMax);
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
    localparam logic [CntWidth-1:0] CntSat  = {CntWidth{1'b1}};

    typedef enum logic {StIdle = 1'b0, StHold = 1'b1} state_e;

    function automatic logic [LineWidth-1:0] line_of(input logic [AddrWidth-1:0] addr);
        return addr[AddrWidth-1:LineOffset];
    endfunction

    state_e                 state_q, state_d;
    logic                   active_q;
    logic                   hold_core_q;
    logic [CntWidth-1:0]    cnt_q [2];
    logic [CntWidth-1:0]    cnt_d [2];
    logic                   last_core_q;
    logic [LineWidth-1:0]   last_line_q;
    logic [CntWidth-1:0]    lock_cnt_q, lock_cnt_d;
    logic                   rr_q;
    logic                   drained_q;

    logic [AddrWidth-1:0]   addr_s [2];
    logic [DataWidth-1:0]   data_s [2];
    logic [StrbWidth-1:0]   strb_s [2];
    logic [UserWidth-1:0]   user_s [2];
    logic [1:0]             elig_s;
    logic                   lock_hit_s;
    logic                   win_s;
    logic                   sel_s;
    logic                   req_valid_s;
    logic                   accept_s;
    logic                   rsp_id_s;
    logic                   rsp_fire_s;
    logic                   same_s;

    // Unpack per-core request fields and evaluate eligibility.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            addr_s[c] = inp_addr_i[c*AddrWidth +: AddrWidth];
            data_s[c] = inp_data_i[c*DataWidth +: DataWidth];
            strb_s[c] = inp_strb_i[c*StrbWidth +: StrbWidth];
            user_s[c] = inp_user_i[c*UserWidth +: UserWidth];
            elig_s[c] = active_q && inp_valid_i[c] && (cnt_q[c] < MaxCnt) && !flush_i;
        end
    end

    // Winner selection: line lock first, round-robin otherwise.
    always_comb begin
        lock_hit_s = 1'b0;
        win_s      = rr_q;
        if (elig_s[last_core_q] && (line_of(addr_s[last_core_q]) == last_line_q)
            && (lock_cnt_q < LockLim)) begin
            lock_hit_s = 1'b1;
            win_s      = last_core_q;
        end else if (elig_s[rr_q]) begin
            win_s = rr_q;
        end else begin
            win_s = ~rr_q;
        end
    end

    // Request mux and handshake; a held request keeps its source core.
    always_comb begin
        sel_s       = (state_q == StHold) ? hold_core_q : win_s;
        req_valid_s = (state_q == StHold) || (|elig_s);
        oup_valid_o = req_valid_s;
        oup_addr_o  = addr_s[sel_s];
        oup_write_o = inp_write_i[sel_s];
        oup_data_o  = data_s[sel_s];
        oup_strb_o  = strb_s[sel_s];
        oup_user_o  = user_s[sel_s];
        oup_user_o[CoreIdBit] = sel_s;
        inp_ready_o = 2'b00;
        if (req_valid_s) begin
            inp_ready_o[sel_s] = oup_ready_i;
        end else begin
            inp_ready_o = 2'b00;
        end
        accept_s = req_valid_s && oup_ready_i;
    end

    // Next-state logic of the grant FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if ((|elig_s) && !oup_ready_i) state_d = StHold;
                else                           state_d = StIdle;
            end
            StHold: begin
                if (oup_ready_i) state_d = StIdle;
                else             state_d = StHold;
            end
            default: state_d = StIdle;
        endcase
    end

    // Response steering by the core-ID tag echoed in the user field.
    always_comb begin
        rsp_id_s         = rsp_user_i[CoreIdBit];
        core_rsp_data_o  = {2{rsp_data_i}};
        core_rsp_valid_o = 2'b00;
        if (active_q && rsp_valid_i) begin
            core_rsp_valid_o[rsp_id_s] = 1'b1;
        end else begin
            core_rsp_valid_o = 2'b00;
        end
        rsp_ready_o = active_q && core_rsp_ready_i[rsp_id_s];
        rsp_fire_s  = rsp_valid_i && rsp_ready_o;
    end

    // Outstanding counters (request and response together cancel) and lock count.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            cnt_d[c] = cnt_q[c];
            if (accept_s && (sel_s == 1'(c)) && !(rsp_fire_s && (rsp_id_s == 1'(c)))) begin
                cnt_d[c] = cnt_q[c] + CntOne;
            end else if (!(accept_s && (sel_s == 1'(c))) && rsp_fire_s
                         && (rsp_id_s == 1'(c)) && (cnt_q[c] != '0)) begin
                cnt_d[c] = cnt_q[c] - CntOne;
            end else begin
                cnt_d[c] = cnt_q[c];
            end
        end
        same_s     = (sel_s == last_core_q) && (line_of(oup_addr_o) == last_line_q);
        lock_cnt_d = lock_cnt_q;
        if (accept_s) begin
            if (same_s) lock_cnt_d = (lock_cnt_q == CntSat) ? lock_cnt_q : lock_cnt_q + CntOne;
            else        lock_cnt_d = CntOne;
        end else begin
            lock_cnt_d = lock_cnt_q;
        end
    end

    // State, counters, arbitration history and drain flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            active_q    <= 1'b0;
            hold_core_q <= 1'b0;
            cnt_q[0]    <= '0;
            cnt_q[1]    <= '0;
            last_core_q <= 1'b0;
            last_line_q <= '0;
            lock_cnt_q  <= '0;
            rr_q        <= 1'b0;
            drained_q   <= 1'b0;
        end else begin
            active_q   <= 1'b1;
            state_q    <= state_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
            lock_cnt_q <= lock_cnt_d;
            drained_q  <= active_q && flush_i && (cnt_q[0] == '0) && (cnt_q[1] == '0)
                          && (state_q == StIdle);
            if ((state_q == StIdle) && (state_d == StHold)) begin
                hold_core_q <= win_s;
            end
            if (accept_s) begin
                last_core_q <= sel_s;
                last_line_q <= line_of(oup_addr_o);
                rr_q        <= ~sel_s;
            end
        end
    end

    assign drained_o = drained_q;

`ifdef SPATZ_PORT_MERGER_STATS_EN
    logic        flush_q;
    logic        hold_lock_q;
    logic        took_lock_s;
    logic [31:0] grant_q [2];
    logic [31:0] lock_q;
    logic [31:0] stall_q;

    assign took_lock_s = (state_q == StHold) ? hold_lock_q : lock_hit_s;

    // Statistics counters; cleared on the rising edge of flush_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flush_q     <= 1'b0;
            hold_lock_q <= 1'b0;
            grant_q[0]  <= 32'd0;
            grant_q[1]  <= 32'd0;
            lock_q      <= 32'd0;
            stall_q     <= 32'd0;
        end else begin
            flush_q <= flush_i;
            if ((state_q == StIdle) && (state_d == StHold)) begin
                hold_lock_q <= lock_hit_s;
            end
            if (flush_i && !flush_q) begin
                grant_q[0] <= 32'd0;
                grant_q[1] <= 32'd0;
                lock_q     <= 32'd0;
                stall_q    <= 32'd0;
            end else begin
                if (accept_s) grant_q[sel_s] <= grant_q[sel_s] + 32'd1;
                if (accept_s && took_lock_s) lock_q <= lock_q + 32'd1;
                if (state_q == StHold) stall_q <= stall_q + 32'd1;
            end
        end
    end

    assign stat_grant_o = {grant_q[1], grant_q[0]};
    assign stat_lock_o  = lock_q;
    assign stat_stall_o = stall_q;
`endif

endmodule

// File: doc/spatz_cache_port_merger.md
Name: spatz_cache_port_merger

Overview:
- Cache-side stage directly downstream of the address mapper: merges the two Spatz core request ports that share one cache bank port into a single stream.
- Arbitrates between the two cores with round-robin fairness and a cache-line lock. Tags each request with its core ID and limits outstanding requests per core.
- Steers cache responses back to the originating core by the tag, with per-core back-pressure. Supports a drain-on-flush handshake.

Parameters:
AddrWidth, 32, request address width
DataWidth, 32, request/response data width
UserWidth, 8, user field width; bit CoreIdBit carries the core ID
CoreIdBit, 0, user bit overwritten with the granted core index
LineOffset, 6, log2 of the cache line size in bytes; line = addr >> LineOffset
MaxOutstanding, 8, maximum unanswered requests per core (1..255)
LockMax, 4, maximum consecutive same-line grants before a forced switch (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
inp_addr_i  in  2xAddrWidth  per-core request address
inp_write_i  in  2  per-core write flag
inp_data_i  in  2xDataWidth  per-core write data
inp_strb_i  in  2xDataWidth/8  per-core byte strobes
inp_user_i  in  2xUserWidth  per-core user field
inp_valid_i  in  2  per-core request valid
inp_ready_o  out  2  per-core request ready
oup_addr_o  out  AddrWidth  merged request address
oup_write_o  out  1  merged write flag
oup_data_o  out  DataWidth  merged write data
oup_strb_o  out  DataWidth/8  merged strobes
oup_user_o  out  UserWidth  merged user; bit CoreIdBit = granted core
oup_valid_o  out  1  merged request valid
oup_ready_i  in  1  cache accepts request
rsp_data_i  in  DataWidth  cache response data
rsp_user_i  in  UserWidth  cache response user (echoes the request user)
rsp_valid_i  in  1  cache response valid
rsp_ready_o  out  1  response accepted (maps to cache p_ready)
core_rsp_data_o  out  2xDataWidth  per-core response data (both driven with rsp_data_i)
core_rsp_valid_o  out  2  per-core response valid
core_rsp_ready_i  in  2  per-core response ready
flush_i  in  1  stop granting new requests
drained_o  out  1  flush_i high and no request in flight

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - oup_valid_o=0, inp_ready_o=0, rsp_ready_o=0, core_rsp_valid_o=0, drained_o=0.
  - Outstanding counters=0, lock counter=0, RR pointer=core 0.
- Eligibility: core c is eligible iff inp_valid_i[c] && cnt[c] < MaxOutstanding && !flush_i.
- States:
  - IDLE: no pending output. When at least one core is eligible, choose winner w:
    - Lock path: if last_core is eligible, line(inp_addr_i[last_core]) == last_line, and lock_cnt < LockMax, then w = last_core.
    - Otherwise round-robin: the eligible core at or after the RR pointer.
    - Drive oup_* combinationally from w with oup_valid_o=1.
    - Handshake in the same cycle: inp_ready_o[w] = oup_ready_i; the other core's ready = 0.
    - If oup_ready_i=0, latch w and go to HOLD.
  - HOLD: oup_* stay sourced from the latched w, unchanged, until oup_ready_i. Eligibility is not re-evaluated; flush_i does not drop a held request (valid/ready stability rule). Return to IDLE on handshake.
- On each accepted request (oup_valid_o && oup_ready_i):
  - cnt[w]++; last_core = w; last_line = line(addr).
  - lock_cnt = (same core and same line as before) ? lock_cnt+1 : 1.
  - RR pointer = other core.
- Latency: 0 cycles input to output (combinational path); no request buffering.
- Response routing:
  - id = rsp_user_i[CoreIdBit].
  - core_rsp_valid_o[id] = rsp_valid_i; the other core's valid = 0.
  - rsp_ready_o = core_rsp_ready_i[id].
  - On response handshake, cnt[id]--.
- Simultaneous request and response on the same core: counter unchanged.
- Response with cnt[id]==0: counter saturates at 0 and response is still forwarded (verification flags it as an error).
- drained_o = flush_i && cnt[0]==0 && cnt[1]==0 && state==IDLE; registered, so it lags one cycle.
- A core blocked at MaxOutstanding resumes the cycle after one of its responses completes.

Optional Feature:
- Macro SPATZ_PORT_MERGER_STATS_EN.
- When defined, adds outputs:
  - stat_grant_o (2x32): per-core accepted-request counts.
  - stat_lock_o (32): grants taken through the lock path.
  - stat_stall_o (32): cycles in HOLD.
- All counters reset to 0, wrap at 2^32, and clear synchronously when flush_i rises.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Both cores valid, addrs 0x1000 and 0x2000, oup_ready_i=1, distinct lines each cycle -> grants alternate 0,1,0,1; oup_user_o[0] matches the winner.
- Core0 streams 0x1000, 0x1004, 0x1008, ... while core1 is valid; LockMax=4 -> core0 wins 4 grants, then core1, then core0 resumes.
- oup_ready_i=0 for 3 cycles with core1 valid after core0 is held -> oup_* stable for 3 cycles, core0 accepted, then core1 is granted.
- Core0 issues 8 requests with no responses (MaxOutstanding=8) -> 9th blocked with inp_ready_o[0]=0 while core1 keeps being granted; one response with user id 0 -> core0 granted next cycle.
- Response user=1 with core_rsp_ready_i=2'b01 -> core_rsp_valid_o=2'b10, rsp_ready_o=0 until ready[1]=1, then cnt[1] decrements.
- 3 outstanding on core0, flush_i=1 -> no new grants; drained_o=1 one cycle after the 3rd response; assert rst_ni mid-flight -> all counters 0 and outputs at reset values.
